// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: retire FSM states and address-width helper.
// Pure definitions, no logic.
package store_buffer_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } state_e;

   function automatic int addr_width(input int mem_size);
      return (mem_size > 1) ? $clog2(mem_size) : 1;
   endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store request, memory write and load-forwarding signals of the store buffer.
// The slave modport is the store buffer itself; master is whoever drives it.
interface store_buffer_if #(
   parameter int ADDR_W     = 6,
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4
);
   logic                    req_valid;
   logic                    req_ready;
   logic [ADDR_W-1:0]       req_addr;
   logic [DATA_WIDTH-1:0]   req_data;

   logic                    mem_we;
   logic [ADDR_W-1:0]       mem_addr;
   logic [DATA_WIDTH-1:0]   mem_data;
   logic                    write_done;

   logic [ADDR_W-1:0]       fwd_addr;
   logic                    fwd_hit;
   logic [DATA_WIDTH-1:0]   fwd_data;

   logic [$clog2(DEPTH):0]  count;
   logic                    empty;

   modport master (
      output req_valid, req_addr, req_data, fwd_addr,
      input  req_ready, mem_we, mem_addr, mem_data, write_done,
      input  fwd_hit, fwd_data, count, empty
   );

   modport slave (
      input  req_valid, req_addr, req_data, fwd_addr,
      output req_ready, mem_we, mem_addr, mem_data, write_done,
      output fwd_hit, fwd_data, count, empty
   );
endinterface

// File: rtl/sb_entry_array.sv
// Circular entry storage with head/tail pointers and youngest-match forwarding search.
// Writes land on the next edge; forwarding is combinational over the registered entries.
module sb_entry_array #(
   parameter int DEPTH      = 4,
   parameter int ADDR_W     = 6,
   parameter int DATA_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push,
   input  logic                    pop,
   input  logic                    merge,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [$clog2(DEPTH):0]  count,
   input  logic [ADDR_W-1:0]       fwd_addr,
   output logic                    fwd_hit,
   output logic [DATA_WIDTH-1:0]   fwd_data,
   output logic [ADDR_W-1:0]       head_addr,
   output logic [DATA_WIDTH-1:0]   head_data,
   output logic [ADDR_W-1:0]       tail_addr
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [ADDR_W-1:0]     addr_q [DEPTH];
   logic [ADDR_W-1:0]     addr_d [DEPTH];
   logic [DATA_WIDTH-1:0] data_q [DEPTH];
   logic [DATA_WIDTH-1:0] data_d [DEPTH];
   logic [PTR_W-1:0]      head_q, head_d;
   logic [PTR_W-1:0]      tail_q, tail_d;
   logic [PTR_W-1:0]      last_idx;
   logic [PTR_W-1:0]      scan_idx;

   assign last_idx  = tail_q - PTR_W'(1);
   assign head_addr = addr_q[head_q];
   assign head_data = data_q[head_q];
   assign tail_addr = addr_q[last_idx];

   always_comb begin
      addr_d = addr_q;
      data_d = data_q;
      head_d = head_q;
      tail_d = tail_q;
      if (push) begin
         addr_d[tail_q] = wr_addr;
         data_d[tail_q] = wr_data;
         tail_d         = tail_q + PTR_W'(1);
      end
      if (merge) begin
         data_d[last_idx] = wr_data;
      end
      if (pop) begin
         head_d = head_q + PTR_W'(1);
      end
   end

   // Walk from the youngest entry back towards the head; first match wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      scan_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         scan_idx = tail_q - PTR_W'(i + 1);
         if (!fwd_hit && (i < int'(count)) && (addr_q[scan_idx] == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[scan_idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      data_q <= data_d;
   end

endmodule

// File: rtl/store_buffer.sv
// Store queue between execute and data memory: coalesces back-to-back same-address stores, forwards to loads.
// Write starts one edge after a store is queued, holds mem_we WRITE_CYCLES cycles; req_ready is low only when full.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DATA_WIDTH       = 8,
   parameter int DATA_MEMORY_SIZE = 64,
   parameter int DEPTH            = 4,
   parameter int WRITE_CYCLES     = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   store_buffer_if.slave  sb
);
   localparam int ADDR_W = addr_width(DATA_MEMORY_SIZE);
   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam int CYC_W  = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;
   localparam logic [CYC_W-1:0] CYC_LOAD = CYC_W'(WRITE_CYCLES - 1);

   state_e                state_q, state_d;
   logic [CYC_W-1:0]      cyc_q, cyc_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
   logic                  write_done_q, write_done_d;

   logic                  req_ready;
   logic                  accept, merge, push, pop;
   logic [ADDR_W-1:0]     head_addr, tail_addr;
   logic [DATA_WIDTH-1:0] head_data;

   assign req_ready = (count_q < CNT_W'(DEPTH));
   assign accept    = sb.req_valid && req_ready;
   // The youngest entry may absorb the store unless it is the head already being written.
   assign merge     = accept && (count_q != '0) && (sb.req_addr == tail_addr)
                      && ((count_q > CNT_W'(1)) || (state_q == ST_IDLE));
   assign push      = accept && !merge;
   assign pop       = (state_q == ST_WRITE) && (cyc_q == '0);

   sb_entry_array #(
      .DEPTH      (DEPTH),
      .ADDR_W     (ADDR_W),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_entries (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .merge     (merge),
      .wr_addr   (sb.req_addr),
      .wr_data   (sb.req_data),
      .count     (count_q),
      .fwd_addr  (sb.fwd_addr),
      .fwd_hit   (sb.fwd_hit),
      .fwd_data  (sb.fwd_data),
      .head_addr (head_addr),
      .head_data (head_data),
      .tail_addr (tail_addr)
   );

   always_comb begin
      state_d      = state_q;
      cyc_d        = cyc_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      write_done_d = 1'b0;
      count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
      case (state_q)
         ST_IDLE: begin
            if (count_q != '0) begin
               state_d    = ST_WRITE;
               cyc_d      = CYC_LOAD;
               mem_we_d   = 1'b1;
               mem_addr_d = head_addr;
               // A merge into a lone idle head lands this edge; take the new data directly.
               mem_data_d = (merge && (count_q == CNT_W'(1))) ? sb.req_data : head_data;
            end
         end
         ST_WRITE: begin
            if (cyc_q == '0) begin
               state_d      = ST_IDLE;
               mem_we_d     = 1'b0;
               write_done_d = 1'b1;
            end else begin
               cyc_d = cyc_q - CYC_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cyc_q        <= '0;
         count_q      <= '0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         write_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cyc_q        <= cyc_d;
         count_q      <= count_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         write_done_q <= write_done_d;
      end
   end

   assign sb.req_ready  = req_ready;
   assign sb.mem_we     = mem_we_q;
   assign sb.mem_addr   = mem_addr_q;
   assign sb.mem_data   = mem_data_q;
   assign sb.write_done = write_done_q;
   assign sb.count      = count_q;
   assign sb.empty      = (count_q == '0);

endmodule

// File: tb/tb_store_buffer.sv
// Store buffer bench: directed scenarios with literal expectations plus a randomized run,
// all checked every cycle against a queue-level reference model.
module tb_store_buffer;
   localparam int DW    = 8;
   localparam int MEMSZ = 64;
   localparam int AW    = 6;
   localparam int DEPTH = 4;
   localparam int WC    = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   store_buffer_if #(.ADDR_W(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) sb ();

   store_buffer #(
      .DATA_WIDTH       (DW),
      .DATA_MEMORY_SIZE (MEMSZ),
      .DEPTH            (DEPTH),
      .WRITE_CYCLES     (WC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sb    (sb)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } entry_t;

   // Reference model: pending stores in age order, plus the memory port it should show.
   entry_t        q[$];
   bit            busy;
   int            rem;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   logic          m_done;

   int     n_vec = 0;
   int     n_bad = 0;
   bit     cmp_en = 1'b0;
   int     done_seen = 0;
   entry_t wlog[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_step();
      bit     acc, mrg, pop_now, start;
      entry_t e;
      if (!rst_n) begin
         q.delete();
         busy   = 1'b0;
         rem    = 0;
         m_we   = 1'b0;
         m_addr = '0;
         m_data = '0;
         m_done = 1'b0;
         return;
      end
      acc     = sb.req_valid && (q.size() < DEPTH);
      mrg     = acc && (q.size() > 0) && (q[q.size()-1].addr == sb.req_addr)
                && ((q.size() > 1) || !busy);
      pop_now = busy && (rem == 0);
      start   = !busy && (q.size() > 0);
      if (mrg) begin
         e = q.pop_back();
         e.data = sb.req_data;
         q.push_back(e);
      end
      m_done = pop_now;
      if (start) begin
         busy   = 1'b1;
         rem    = WC - 1;
         m_we   = 1'b1;
         m_addr = q[0].addr;
         m_data = q[0].data;
      end else if (pop_now) begin
         void'(q.pop_front());
         busy = 1'b0;
         m_we = 1'b0;
      end else if (busy) begin
         rem--;
      end
      if (acc && !mrg) q.push_back('{sb.req_addr, sb.req_data});
   endfunction

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
   endtask

   always @(negedge clk) begin : compare
      bit            h;
      logic [DW-1:0] d;
      if (cmp_en) begin
         h = 1'b0;
         d = '0;
         for (int i = q.size() - 1; i >= 0; i--) begin
            if (!h && (q[i].addr == sb.fwd_addr)) begin
               h = 1'b1;
               d = q[i].data;
            end
         end
         chk("req_ready",  32'(sb.req_ready),  32'(q.size() < DEPTH));
         chk("count",      32'(sb.count),      32'(q.size()));
         chk("empty",      32'(sb.empty),      32'(q.size() == 0));
         chk("mem_we",     32'(sb.mem_we),     32'(m_we));
         chk("mem_addr",   32'(sb.mem_addr),   32'(m_addr));
         chk("mem_data",   32'(sb.mem_data),   32'(m_data));
         chk("write_done", 32'(sb.write_done), 32'(m_done));
         chk("fwd_hit",    32'(sb.fwd_hit),    32'(h));
         chk("fwd_data",   32'(sb.fwd_data),   32'(d));
      end
      if (sb.write_done) begin
         done_seen++;
         wlog.push_back('{sb.mem_addr, sb.mem_data});
      end
   end

   task automatic push_req(input logic [AW-1:0] a, input logic [DW-1:0] d);
      sb.req_valid = 1'b1;
      sb.req_addr  = a;
      sb.req_data  = d;
      for (int k = 0; k < 100; k++) begin
         if (sb.req_ready) begin
            step();
            sb.req_valid = 1'b0;
            return;
         end
         step();
      end
      chk("push_timeout", 32'(sb.req_ready), 32'd1);
      sb.req_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      for (int k = 0; k < budget; k++) begin
         if (sb.empty && !sb.mem_we) begin
            step();
            return;
         end
         step();
      end
      chk("drain_timeout", 32'(sb.empty), 32'd1);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int w0, d0;
      sb.req_valid = 1'b0;
      sb.req_addr  = '0;
      sb.req_data  = '0;
      sb.fwd_addr  = '0;
      rst_n        = 1'b0;
      step();
      step();
      cmp_en = 1'b1;
      chk("rst_ready",  32'(sb.req_ready), 32'd1);
      chk("rst_empty",  32'(sb.empty),     32'd1);
      chk("rst_fwd",    32'(sb.fwd_hit),   32'd0);
      chk("rst_mem_we", 32'(sb.mem_we),    32'd0);
      rst_n = 1'b1;

      // Single store
      sb.req_valid = 1'b1; sb.req_addr = 6'd5; sb.req_data = 8'hA3;
      step();
      sb.req_valid = 1'b0;
      chk("s_count", 32'(sb.count),  32'd1);
      chk("s_we0",   32'(sb.mem_we), 32'd0);
      step();
      chk("s_we1",   32'(sb.mem_we),   32'd1);
      chk("s_addr",  32'(sb.mem_addr), 32'd5);
      chk("s_data",  32'(sb.mem_data), 32'hA3);
      step();
      step();
      chk("s_we3",   32'(sb.mem_we),     32'd1);
      chk("s_done0", 32'(sb.write_done), 32'd0);
      step();
      chk("s_we_off", 32'(sb.mem_we),     32'd0);
      chk("s_done",   32'(sb.write_done), 32'd1);
      chk("s_empty",  32'(sb.empty),      32'd1);
      step();
      chk("s_done_1cyc", 32'(sb.write_done), 32'd0);

      // Fill and backpressure
      d0 = done_seen;
      w0 = wlog.size();
      for (int i = 0; i < 6; i++) begin
         push_req(AW'(i), DW'(8'h10 + i));
         if (i == 3) begin
            chk("full_count", 32'(sb.count),     32'd4);
            chk("full_ready", 32'(sb.req_ready), 32'd0);
            chk("full_model", 32'(q.size()),     32'd4);
         end
      end
      drain(200);
      chk("fill_done", 32'(done_seen - d0), 32'd6);
      for (int i = 0; i < 6; i++) begin
         if (w0 + i < wlog.size()) begin
            chk("fill_addr", 32'(wlog[w0+i].addr), 32'(i));
            chk("fill_data", 32'(wlog[w0+i].data), 32'(8'h10 + i));
         end
      end

      // Merge behind an in-flight head
      w0 = wlog.size();
      push_req(6'd3, 8'h44);
      step();
      chk("m_inflight", 32'(sb.mem_we), 32'd1);
      push_req(6'd7, 8'h11);
      push_req(6'd7, 8'h22);
      chk("m_count", 32'(sb.count), 32'd2);
      drain(200);
      chk("m_writes", 32'(wlog.size() - w0), 32'd2);
      if (wlog.size() >= w0 + 2) begin
         chk("m_addr", 32'(wlog[w0+1].addr), 32'd7);
         chk("m_data", 32'(wlog[w0+1].data), 32'h22);
      end

      // No merge into the head being written
      w0 = wlog.size();
      push_req(6'd7, 8'h11);
      step();
      push_req(6'd7, 8'h33);
      chk("nm_count", 32'(sb.count), 32'd2);
      drain(200);
      chk("nm_writes", 32'(wlog.size() - w0), 32'd2);
      if (wlog.size() >= w0 + 2) begin
         chk("nm_first", 32'(wlog[w0].data),   32'h11);
         chk("nm_last",  32'(wlog[w0+1].data), 32'h33);
      end

      // Forwarding
      push_req(6'd9, 8'h01);
      push_req(6'd4, 8'h02);
      push_req(6'd9, 8'h03);
      chk("f_count", 32'(sb.count), 32'd3);
      sb.fwd_addr = 6'd9; #1;
      chk("f9_hit",  32'(sb.fwd_hit),  32'd1);
      chk("f9_data", 32'(sb.fwd_data), 32'h03);
      sb.fwd_addr = 6'd4; #1;
      chk("f4_hit",  32'(sb.fwd_hit),  32'd1);
      chk("f4_data", 32'(sb.fwd_data), 32'h02);
      sb.fwd_addr = 6'd8; #1;
      chk("f8_hit",  32'(sb.fwd_hit),  32'd0);
      chk("f8_data", 32'(sb.fwd_data), 32'h00);
      drain(200);

      // Reset during the second mem_we cycle with three queued
      push_req(6'd20, 8'hB0);
      push_req(6'd21, 8'hB1);
      push_req(6'd22, 8'hB2);
      chk("r_count_pre", 32'(sb.count),  32'd3);
      chk("r_we_pre",    32'(sb.mem_we), 32'd1);
      d0 = done_seen;
      rst_n = 1'b0;
      step();
      chk("r_we",    32'(sb.mem_we),     32'd0);
      chk("r_count", 32'(sb.count),      32'd0);
      chk("r_ready", 32'(sb.req_ready),  32'd1);
      chk("r_done",  32'(sb.write_done), 32'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         chk("r_quiet_we", 32'(sb.mem_we), 32'd0);
      end
      chk("r_no_done", 32'(done_seen - d0), 32'd0);

      // Randomized traffic with a narrow address range to provoke merges and forwarding hits
      for (int c = 0; c < 3000; c++) begin
         rst_n        = ($urandom_range(0, 299) != 0);
         sb.req_valid = ($urandom_range(0, 9) < 6);
         sb.req_addr  = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 3));
         sb.req_data  = DW'($urandom);
         sb.fwd_addr  = AW'($urandom_range(0, 4));
         step();
      end
      rst_n        = 1'b1;
      sb.req_valid = 1'b0;
      drain(200);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
